exu_alu_sequencer: RTL and testbench



---
 rtl/exu_alu_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_exu_alu_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_alu_sequencer.sv
// exu_alu_sequencer: multicycle execute controller driving a combinational ALU.
// Sequences an ALU op or a branch compare plus target add, adds an optional
// LFSR-derived delay, then presents the result downstream under valid/ready.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     issue handshake (ready only in IDLE)
//   in_kind               0 = ALU op, 1 = conditional branch
//   in_aluop, in_a, in_b  ALU op code and operands
//   in_pc, in_imm         branch PC and B-immediate
//   in_br_func            branch funct3
//   alu_op/num1/num2      to the ALU; alu_res is its combinational answer
//   out_valid/out_ready   result handshake
//   out_res, out_taken, out_target  result fields
module exu_alu_sequencer #(
   parameter bit          RAND_DELAY = 1'b1,
   parameter int unsigned DELAY_W    = 3,
   parameter logic [7:0]  SEED       = 8'hA5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_kind,
   input  logic [3:0]  in_aluop,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_imm,
   input  logic [2:0]  in_br_func,
   output logic [3:0]  alu_op,
   output logic [31:0] alu_num1,
   output logic [31:0] alu_num2,
   input  logic [31:0] alu_res,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_res,
   output logic        out_taken,
   output logic [31:0] out_target
);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_LTS = 4'd5;
   localparam logic [3:0] OP_LTU = 4'd9;
   localparam logic [3:0] OP_EQ  = 4'd10;

   typedef enum logic [2:0] {
      S_IDLE, S_EXEC, S_CMP, S_TGT, S_WAIT, S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [3:0]         r_aluop;
   logic [31:0]        r_a;
   logic [31:0]        r_b;
   logic [31:0]        r_pc;
   logic [31:0]        r_imm;
   logic [2:0]         r_f3;
   logic [31:0]        r_res;
   logic               r_taken;
   logic [31:0]        r_target;
   logic [DELAY_W-1:0] r_cnt;
   logic [7:0]         r_lfsr;

   logic [DELAY_W-1:0] w_delay;
   logic               w_fb;
   logic [3:0]         w_cmp_op;
   logic               w_illegal;
   logic               w_taken;
   logic               w_accept;

   // x^8+x^6+x^5+x^4+1, shifting toward the MSB
   assign w_fb     = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
   assign w_delay  = RAND_DELAY ? r_lfsr[DELAY_W-1:0] : '0;
   assign w_accept = (r_state == S_IDLE) && in_valid;

   // funct3[2:1] picks the compare, funct3[0] inverts it
   always_comb begin
      w_cmp_op  = OP_EQ;
      w_illegal = 1'b0;
      unique case (r_f3[2:1])
         2'b00: w_cmp_op = OP_EQ;
         2'b01: w_illegal = 1'b1;
         2'b10: w_cmp_op = OP_LTS;
         2'b11: w_cmp_op = OP_LTU;
      endcase
   end

   assign w_taken = ~w_illegal & (alu_res[0] ^ r_f3[0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      alu_op   = 4'd0;
      alu_num1 = 32'd0;
      alu_num2 = 32'd0;
      case (r_state)
         S_IDLE: begin
            if (in_valid) w_next = in_kind ? S_CMP : S_EXEC;
         end
         S_EXEC: begin
            alu_op   = r_aluop;
            alu_num1 = r_a;
            alu_num2 = r_b;
            w_next   = (w_delay != '0) ? S_WAIT : S_DONE;
         end
         S_CMP: begin
            alu_op   = w_cmp_op;
            alu_num1 = r_a;
            alu_num2 = r_b;
            w_next   = S_TGT;
         end
         S_TGT: begin
            alu_op   = OP_ADD;
            alu_num1 = r_pc;
            alu_num2 = r_imm;
            w_next   = (w_delay != '0) ? S_WAIT : S_DONE;
         end
         S_WAIT: begin
            if (r_cnt == DELAY_W'(1)) w_next = S_DONE;
         end
         S_DONE: begin
            if (out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_aluop  <= 4'd0;
         r_a      <= 32'd0;
         r_b      <= 32'd0;
         r_pc     <= 32'd0;
         r_imm    <= 32'd0;
         r_f3     <= 3'd0;
         r_res    <= 32'd0;
         r_taken  <= 1'b0;
         r_target <= 32'd0;
         r_cnt    <= '0;
         r_lfsr   <= SEED;
      end else begin
         r_lfsr <= {r_lfsr[6:0], w_fb};
         if (w_accept) begin
            r_aluop  <= in_aluop;
            r_a      <= in_a;
            r_b      <= in_b;
            r_pc     <= in_pc;
            r_imm    <= in_imm;
            r_f3     <= in_br_func;
            r_res    <= 32'd0;
            r_taken  <= 1'b0;
            r_target <= 32'd0;
         end
         case (r_state)
            S_EXEC: begin
               r_res <= alu_res;
               r_cnt <= w_delay;
            end
            S_CMP: begin
               r_res   <= alu_res;
               r_taken <= w_taken;
            end
            S_TGT: begin
               r_target <= alu_res;
               r_cnt    <= w_delay;
            end
            S_WAIT: r_cnt <= r_cnt - DELAY_W'(1);
            default: ;
         endcase
      end
   end

   assign in_ready   = (r_state == S_IDLE);
   assign out_valid  = (r_state == S_DONE);
   assign out_res    = r_res;
   assign out_taken  = r_taken;
   assign out_target = r_target;

endmodule

// File: tb/tb_exu_alu_sequencer.sv
// tb_exu_alu_sequencer: random and directed checks of exu_alu_sequencer
// against a behavioural ALU/branch/LFSR-delay reference model.
module tb_exu_alu_sequencer;

   localparam int         DW   = 3;
   localparam logic [7:0] SEED = 8'hA5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              kind;
   logic [3:0]        aluop;
   logic [31:0]       a, b, pc, imm;
   logic [2:0]        f3;
   logic [1:0]        iv, ordy, irdy, ov, otk;
   logic [1:0][3:0]   aop;
   logic [1:0][31:0]  an1, an2, ares, ores, otg;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   logic [7:0] m_lfsr;

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(input logic [3:0] op,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
      case (op)
         4'd0:  alu_f = x + y;
         4'd1:  alu_f = x - y;
         4'd2:  alu_f = x ^ y;
         4'd3:  alu_f = x | y;
         4'd4:  alu_f = x & y;
         4'd5:  alu_f = {31'd0, $signed(x) < $signed(y)};
         4'd6:  alu_f = x << y[4:0];
         4'd7:  alu_f = x >> y[4:0];
         4'd8:  alu_f = 32'($signed(x) >>> y[4:0]);
         4'd9:  alu_f = {31'd0, x < y};
         4'd10: alu_f = {31'd0, x == y};
         default: alu_f = 32'd0;
      endcase
   endfunction

   function automatic logic [7:0] lnext(input logic [7:0] l);
      lnext = {l[6:0], ^(l & 8'hB8)};
   endfunction

   assign ares[0] = alu_f(aop[0], an1[0], an2[0]);
   assign ares[1] = alu_f(aop[1], an1[1], an2[1]);

   exu_alu_sequencer #(.RAND_DELAY(1'b0), .DELAY_W(DW), .SEED(SEED)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv[0]), .in_ready(irdy[0]),
      .in_kind(kind), .in_aluop(aluop), .in_a(a), .in_b(b),
      .in_pc(pc), .in_imm(imm), .in_br_func(f3),
      .alu_op(aop[0]), .alu_num1(an1[0]), .alu_num2(an2[0]),
      .alu_res(ares[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]),
      .out_res(ores[0]), .out_taken(otk[0]), .out_target(otg[0])
   );

   exu_alu_sequencer #(.RAND_DELAY(1'b1), .DELAY_W(DW), .SEED(SEED)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv[1]), .in_ready(irdy[1]),
      .in_kind(kind), .in_aluop(aluop), .in_a(a), .in_b(b),
      .in_pc(pc), .in_imm(imm), .in_br_func(f3),
      .alu_op(aop[1]), .alu_num1(an1[1]), .alu_num2(an2[1]),
      .alu_res(ares[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]),
      .out_res(ores[1]), .out_taken(otk[1]), .out_target(otg[1])
   );

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) m_lfsr = lnext(m_lfsr);
      else       m_lfsr = SEED;
      cyc++;
      @(negedge clk);
   endtask

   task automatic scramble();
      kind  = 1'($urandom);
      aluop = 4'($urandom);
      a     = $urandom;
      b     = $urandom;
      pc    = $urandom;
      imm   = $urandom;
      f3    = 3'($urandom);
   endtask

   task automatic run_op(input int s, input logic k, input logic [3:0] op,
                         input logic [31:0] xa, input logic [31:0] xb,
                         input logic [31:0] xpc, input logic [31:0] ximm,
                         input logic [2:0] xf3, input bit hold);
      logic [31:0] er, eg;
      logic        et, eq, lts, ltu;
      logic [7:0]  lf;
      int          d, acc, n;
      eq  = (xa == xb);
      lts = ($signed(xa) < $signed(xb));
      ltu = (xa < xb);
      er  = 32'd0;
      et  = 1'b0;
      eg  = 32'd0;
      if (!k) begin
         er = alu_f(op, xa, xb);
      end else begin
         eg = xpc + ximm;
         case (xf3)
            3'b000: begin er = {31'd0, eq};  et = eq;   end
            3'b001: begin er = {31'd0, eq};  et = !eq;  end
            3'b100: begin er = {31'd0, lts}; et = lts;  end
            3'b101: begin er = {31'd0, lts}; et = !lts; end
            3'b110: begin er = {31'd0, ltu}; et = ltu;  end
            3'b111: begin er = {31'd0, ltu}; et = !ltu; end
            default: begin er = {31'd0, eq}; et = 1'b0; end
         endcase
      end
      // delay is the LFSR value in the EXEC (k=0) or TGT (k=1) cycle
      d = 0;
      if (s == 1) begin
         lf = m_lfsr;
         repeat (k ? 2 : 1) lf = lnext(lf);
         d = int'(lf[DW-1:0]);
      end
      kind  = k;
      aluop = op;
      a     = xa;
      b     = xb;
      pc    = xpc;
      imm   = ximm;
      f3    = xf3;
      iv[s]   = 1'b1;
      ordy[s] = !hold;
      check("in_ready_idle", irdy[s], 1'b1);
      acc = cyc;
      step();
      iv[s] = 1'b0;
      scramble();
      n = 0;
      while (!ov[s] && n < 60) begin
         step();
         n++;
      end
      check("latency", cyc - acc, (k ? 3 : 2) + d);
      check("out_res", ores[s], er);
      check("out_taken", otk[s], et);
      check("out_target", otg[s], eg);
      check("busy_ready", irdy[s], 1'b0);
      if (hold) begin
         repeat (10) begin
            iv[s] = 1'($urandom);
            scramble();
            step();
            check("hold_stable",
                  {ov[s], irdy[s], otk[s], ores[s], otg[s]},
                  {1'b1, 1'b0, et, er, eg});
         end
         iv[s]   = 1'b0;
         ordy[s] = 1'b1;
      end
      step();
      check("post_hs", {ov[s], irdy[s], aop[s], an1[s], an2[s]},
            {1'b0, 1'b1, 4'd0, 32'd0, 32'd0});
   endtask

   initial begin
      logic [7:0] lf;
      int         n;
      rst_n  = 1'b0;
      iv     = '0;
      ordy   = '0;
      m_lfsr = SEED;
      kind   = 1'b0;
      aluop  = 4'd0;
      a      = 32'd0;
      b      = 32'd0;
      pc     = 32'd0;
      imm    = 32'd0;
      f3     = 3'd0;
      repeat (3) step();
      for (int s = 0; s < 2; s++) begin
         check("reset_ctl", {irdy[s], ov[s], otk[s]}, 3'b100);
         check("reset_dat", {ores[s], otg[s], aop[s], an1[s], an2[s]},
               '0);
      end
      rst_n = 1'b1;

      run_op(0, 1'b0, 4'd1, 32'd5, 32'd7, 32'd0, 32'd0, 3'd0, 1'b0);
      check("sub_const", ores[0], 32'hFFFFFFFE);
      run_op(0, 1'b1, 4'd0, 32'hFFFFFFFF, 32'd1, 32'h80000010,
             32'hFFFFFFF0, 3'b100, 1'b0);
      check("blt_const", {otk[0], ores[0], otg[0]},
            {1'b1, 32'd1, 32'h80000000});
      run_op(0, 1'b1, 4'd0, 32'hFFFFFFFF, 32'd1, 32'h80000010,
             32'hFFFFFFF0, 3'b111, 1'b0);
      check("bgeu_const", otk[0], 1'b1);
      run_op(0, 1'b1, 4'd0, 32'hFFFFFFFF, 32'd1, 32'h80000010,
             32'hFFFFFFF0, 3'b010, 1'b0);
      check("illegal_const", otk[0], 1'b0);

      for (int i = 0; i < 20; i++)
         run_op(1, 1'b0, 4'd0, $urandom, $urandom, $urandom, $urandom,
                3'($urandom), 1'b0);

      run_op(1, 1'b1, 4'd0, 32'd3, 32'd3, 32'h1000, 32'h20, 3'b000, 1'b1);
      run_op(1, 1'b0, 4'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 32'd0,
             3'd0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         run_op(i % 2, 1'($urandom), 4'($urandom),
                ($urandom % 4 == 0) ? 32'h80000000 : $urandom,
                ($urandom % 4 == 0) ? 32'h80000000 : $urandom,
                $urandom, $urandom, 3'($urandom), 1'b0);
      end

      n  = 0;
      lf = lnext(m_lfsr);
      while (lf[DW-1:0] < 3'd2 && n < 300) begin
         step();
         lf = lnext(m_lfsr);
         n++;
      end
      kind  = 1'b0;
      aluop = 4'd0;
      a     = 32'h1234;
      b     = 32'h1;
      iv[1] = 1'b1;
      ordy[1] = 1'b1;
      step();
      iv[1] = 1'b0;
      step();
      check("in_wait", {ov[1], irdy[1]}, 2'b00);
      rst_n  = 1'b0;
      m_lfsr = SEED;
      #1;
      check("arst_ctl", {irdy[1], ov[1], otk[1]}, 3'b100);
      check("arst_dat", {ores[1], otg[1], aop[1], an1[1], an2[1]}, '0);
      repeat (3) begin
         step();
         check("rst_hold", ov[1], 1'b0);
      end
      rst_n = 1'b1;
      run_op(1, 1'b0, 4'd6, 32'h1, 32'd31, 32'd0, 32'd0, 3'd0, 1'b0);
      check("post_rst_const", ores[1], 32'h80000000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
